// File: rtl/duty_pkg.sv
// duty_pkg: shared types, defaults and step arithmetic for the duty ramp
// controller and its period timer.
package duty_pkg;

  localparam int DUTY_DW    = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // One ramp step from cur toward tgt, saturating at tgt. Evaluated in 32 bits
  // so cur+step can never wrap for any duty width the controller supports.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] step);
    logic [31:0] r;
    if (cur < tgt) begin
      r = cur + step;
      if (r > tgt) r = tgt;
    end else if (cur > tgt) begin
      // compare against tgt+step instead of computing cur-step first: no underflow
      r = (cur > tgt + step) ? (cur - step) : tgt;
    end else begin
      r = cur;
    end
    return r;
  endfunction

endpackage

// File: rtl/duty_ramp_ctrl_period_timer.sv
// period_timer: free-running mod-PERIOD counter. tick_o is high while the
// count sits at PERIOD-1, i.e. on the last clock of every PWM period. The PWM
// stage can instantiate the same block so both wrap on the same edge.
module period_timer
  import duty_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: wrap after the last clock of the period
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // counter register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: soft-start / slew-rate limiter feeding the PWM duty input.
// Accepts a target over valid/ready and walks duty_out_o toward it by STEP
// every HOLD_PERIODS PWM periods, changing duty only on period boundaries.
// Build option: define DUTY_CLAMP_EN to clamp accepted targets to MAX_DUTY.
//
// state | meaning
// IDLE  | duty_out equals the accepted target
// RAMP  | stepping toward the target on every HOLD_PERIODS-th period tick
module duty_ramp_ctrl
  import duty_pkg::*;
#(
  parameter int DW           = DUTY_DW,
  parameter int PERIOD       = PWM_PERIOD,
  parameter int STEP         = 1,
  parameter int HOLD_PERIODS = 4,
  parameter int MAX_DUTY     = 230
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic [DW-1:0] tgt_duty_i,
  input  logic          tgt_valid_i,
  output logic          tgt_ready_o,
  output logic [DW-1:0] duty_out_o,
  output logic          period_tick_o,
  output logic          busy_o,
  output logic          at_target_o
);

  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q, at_target_q;
  logic          period_tick;
  logic [DW-1:0] tgt_in;

  period_timer #(
    .PERIOD (PERIOD)
  ) u_period_timer (
    .clk    (clk),
    .rst    (rst),
    .tick_o (period_tick)
  );

  assign tgt_ready_o = enable_i & rst;

`ifdef DUTY_CLAMP_EN
  assign tgt_in = (tgt_duty_i > DW'(MAX_DUTY)) ? DW'(MAX_DUTY) : tgt_duty_i;
`else
  assign tgt_in = tgt_duty_i;
`endif

  // next-state: step on the hold boundary against the current target, then
  // latch any new target; state follows whether duty and target now differ
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    if (!enable_i) begin
      state_d = IDLE;
      duty_d  = '0;
      tgt_d   = '0;
      hold_d  = '0;
    end else begin
      if ((state_q == RAMP) && period_tick) begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          duty_d = DW'(sat_step(32'(duty_q), 32'(tgt_q), 32'(STEP)));
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      if (tgt_valid_i && tgt_ready_o) tgt_d = tgt_in;
      if (duty_d == tgt_d) begin
        state_d = IDLE;
        hold_d  = '0;
      end else begin
        state_d = RAMP;
        // a retarget mid-ramp keeps the hold phase; only a fresh ramp restarts it
        if (state_q == IDLE) hold_d = '0;
      end
    end
  end

  // state and registered status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      tgt_q       <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      hold_q      <= hold_d;
      busy_q      <= (state_d == RAMP);
      at_target_q <= (state_d == IDLE);
    end
  end

  assign duty_out_o    = duty_q;
  assign period_tick_o = period_tick;
  assign busy_o        = busy_q;
  assign at_target_o   = at_target_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb_duty_ramp_ctrl: directed bench for duty_ramp_ctrl with PERIOD=8,
// STEP=16, HOLD_PERIODS=2. Build with DUTY_CLAMP_EN to exercise the clamp.
module tb_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] tgt_duty;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] duty_out;
  logic       period_tick;
  logic       busy;
  logic       at_target;

  int n_vec = 0;
  int n_err = 0;

`ifdef DUTY_CLAMP_EN
  localparam logic [7:0] TOP = 8'd230;
`else
  localparam logic [7:0] TOP = 8'd255;
`endif

  always #5 clk = ~clk;

  duty_ramp_ctrl #(
    .DW           (8),
    .PERIOD       (8),
    .STEP         (16),
    .HOLD_PERIODS (2),
    .MAX_DUTY     (230)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .tgt_duty_i    (tgt_duty),
    .tgt_valid_i   (tgt_valid),
    .tgt_ready_o   (tgt_ready),
    .duty_out_o    (duty_out),
    .period_tick_o (period_tick),
    .busy_o        (busy),
    .at_target_o   (at_target)
  );

  // offer one target for exactly one edge
  task automatic send(input logic [7:0] t);
    tgt_duty  = t;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  // wait (from a negedge) for duty_out to change; report value, whether the
  // changing edge was a period_tick edge, and how many edges it took
  task automatic wait_change(input int budget, output logic [7:0] val,
                             output bit on_tick, output int gap, output bit tmo);
    logic [7:0] prev;
    bit tk;
    prev = duty_out;
    val = prev; on_tick = 1'b0; gap = 0; tmo = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tk = period_tick;
      @(negedge clk);
      if (duty_out !== prev) begin
        val = duty_out; on_tick = tk; gap = i; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd200;
    repeat (3) @(negedge clk);
    n_vec++; if (duty_out !== 8'd0) begin n_err++; $display("FAIL reset_duty: got %0d want 0", duty_out); end
    n_vec++; if (tgt_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", tgt_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reset_at_target: got %b want 1", at_target); end
    n_vec++; if (period_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", period_tick); end
    rst = 1'b1; tgt_valid = 1'b0;
    #1;
    n_vec++; if (tgt_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", tgt_ready); end
    @(negedge clk);
    n_vec++; if (duty_out !== 8'd0) begin n_err++; $display("FAIL release_duty: got %0d want 0", duty_out); end
  endtask

  task automatic test_ramp_up();
    logic [7:0] v; bit tk; int g; bit tmo;
    send(8'd64);
    n_vec++; if (busy !== 1'b1 || at_target !== 1'b0) begin n_err++; $display("FAIL up_flags_start: got busy=%b at=%b want 1 0", busy, at_target); end
    for (int i = 1; i <= 4; i++) begin
      wait_change(40, v, tk, g, tmo);
      n_vec++; if (tmo || v !== 8'(16 * i)) begin n_err++; $display("FAIL up_val%0d: got %0d want %0d tmo=%b", i, v, 16 * i, tmo); end
      n_vec++; if (!tk) begin n_err++; $display("FAIL up_tick%0d: got off-tick change want tick edge", i); end
      if (i > 1) begin
        n_vec++; if (g != 16) begin n_err++; $display("FAIL up_gap%0d: got %0d want 16", i, g); end
      end
    end
    n_vec++; if (busy !== 1'b0 || at_target !== 1'b1) begin n_err++; $display("FAIL up_flags_end: got busy=%b at=%b want 0 1", busy, at_target); end
  endtask

  task automatic test_saturate();
    logic [7:0] v; bit tk; int g; bit tmo;
    send(8'd70);
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd70) begin n_err++; $display("FAIL sat_up: got %0d want 70 tmo=%b", v, tmo); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL sat_up_at: got %b want 1", at_target); end
    send(8'd64);
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd64) begin n_err++; $display("FAIL sat_down: got %0d want 64 tmo=%b", v, tmo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_down_busy: got %b want 0", busy); end
  endtask

  task automatic test_retarget();
    logic [7:0] v; bit tk; int g; bit tmo;
    send(8'd0);
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd48) begin n_err++; $display("FAIL rt_first: got %0d want 48 tmo=%b", v, tmo); end
    send(8'd96);
    for (int i = 1; i <= 3; i++) begin
      wait_change(40, v, tk, g, tmo);
      n_vec++; if (tmo || v !== 8'(48 + 16 * i)) begin n_err++; $display("FAIL rt_val%0d: got %0d want %0d tmo=%b", i, v, 48 + 16 * i, tmo); end
      n_vec++; if (g != ((i == 1) ? 15 : 16)) begin n_err++; $display("FAIL rt_gap%0d: got %0d want %0d", i, g, (i == 1) ? 15 : 16); end
    end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL rt_at: got %b want 1", at_target); end
  endtask

  // target accepted on the very edge that steps: the step uses the old target
  task automatic test_back_to_back();
    logic [7:0] v; bit tk; int g; bit tmo;
    send(8'd160);
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd112) begin n_err++; $display("FAIL b2b_first: got %0d want 112 tmo=%b", v, tmo); end
    repeat (15) @(negedge clk);
    tgt_duty = 8'd100; tgt_valid = 1'b1;
    wait_change(2, v, tk, g, tmo);
    tgt_valid = 1'b0;
    n_vec++; if (tmo || v !== 8'd128) begin n_err++; $display("FAIL b2b_oldtgt: got %0d want 128 tmo=%b", v, tmo); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd112 || g != 16) begin n_err++; $display("FAIL b2b_down1: got %0d gap %0d want 112 gap 16", v, g); end
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== 8'd100) begin n_err++; $display("FAIL b2b_down2: got %0d want 100 tmo=%b", v, tmo); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL b2b_at: got %b want 1", at_target); end
  endtask

  task automatic test_enable();
    logic [7:0] v; bit tk; int g; bit tmo;
    logic [7:0] exp_down [5] = '{8'd84, 8'd68, 8'd64, 8'd48, 8'd32};
    send(8'd64);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) send(8'd0);
      wait_change(40, v, tk, g, tmo);
      n_vec++; if (tmo || v !== exp_down[i]) begin n_err++; $display("FAIL en_pre%0d: got %0d want %0d tmo=%b", i, v, exp_down[i], tmo); end
    end
    enable = 1'b0;
    #1;
    n_vec++; if (tgt_ready !== 1'b0) begin n_err++; $display("FAIL en_ready: got %b want 0", tgt_ready); end
    @(negedge clk);
    n_vec++; if (duty_out !== 8'd0) begin n_err++; $display("FAIL en_off_duty: got %0d want 0", duty_out); end
    n_vec++; if (busy !== 1'b0 || at_target !== 1'b1) begin n_err++; $display("FAIL en_off_flags: got busy=%b at=%b want 0 1", busy, at_target); end
    repeat (5) @(negedge clk);
    enable = 1'b1;
    send(8'd32);
    for (int i = 1; i <= 2; i++) begin
      wait_change(40, v, tk, g, tmo);
      n_vec++; if (tmo || v !== 8'(16 * i)) begin n_err++; $display("FAIL en_re%0d: got %0d want %0d tmo=%b", i, v, 16 * i, tmo); end
    end
    send(8'd32);
    n_vec++; if (busy !== 1'b0 || at_target !== 1'b1) begin n_err++; $display("FAIL en_same_tgt: got busy=%b at=%b want 0 1", busy, at_target); end
  endtask

  task automatic test_boundary();
    logic [7:0] v; bit tk; int g; bit tmo;
    int exp_i;
    exp_i = 32;
    send(8'd255);
    for (int n = 0; n < 20 && exp_i != int'(TOP); n++) begin
      exp_i = (exp_i + 16 > int'(TOP)) ? int'(TOP) : exp_i + 16;
      wait_change(40, v, tk, g, tmo);
      n_vec++; if (tmo || v !== 8'(exp_i)) begin n_err++; $display("FAIL bnd_val: got %0d want %0d tmo=%b", v, exp_i, tmo); end
      if (tmo) break;
      n_vec++; if (!tk) begin n_err++; $display("FAIL bnd_tick: got off-tick change at %0d want tick edge", v); end
    end
    repeat (40) @(negedge clk);
    n_vec++; if (duty_out !== TOP || at_target !== 1'b1) begin n_err++; $display("FAIL bnd_final: got %0d at=%b want %0d at=1", duty_out, at_target, TOP); end
    send(8'd0);
    wait_change(40, v, tk, g, tmo);
    n_vec++; if (tmo || v !== TOP - 8'd16) begin n_err++; $display("FAIL bnd_down: got %0d want %0d tmo=%b", v, TOP - 8'd16, tmo); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (duty_out !== 8'd0) begin n_err++; $display("FAIL midrst_duty: got %0d want 0", duty_out); end
    n_vec++; if (busy !== 1'b0 || at_target !== 1'b1 || tgt_ready !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got busy=%b at=%b rdy=%b want 0 1 0", busy, at_target, tgt_ready); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (duty_out !== 8'd0) begin n_err++; $display("FAIL midrst_stay: got %0d want 0", duty_out); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturate();
    test_retarget();
    test_back_to_back();
    test_enable();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/duty_ramp_ctrl.md
Name: duty_ramp_ctrl

Overview:
Soft-start/slew-rate controller directly upstream of the 8-bit PWM generator; drives its duty-cycle input.
- Accepts a target duty via valid/ready handshake.
- Steps its duty output toward the target by a fixed increment every N PWM periods.
- Changes duty only at PWM period boundaries, so the downstream comparator never sees a mid-period update.

Parameters:
DW, 8, duty width; equals downstream PWM counter width
PERIOD, 256, clocks per PWM period; matches the downstream free-running counter (0..255)
STEP, 1, duty increment/decrement per ramp step, 1..2^DW-1
HOLD_PERIODS, 4, PWM periods between consecutive steps, >=1
MAX_DUTY, 230, clamp ceiling, used only with DUTY_CLAMP_EN

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
enable  in  1  run enable; low forces output off
tgt_duty  in  DW  requested target duty
tgt_valid  in  1  target offered
tgt_ready  out  1  target can be accepted
duty_out  out  DW  duty to PWM stage
period_tick  out  1  one-cycle pulse on last clock of each PWM period
busy  out  1  ramp in progress
at_target  out  1  duty_out equals accepted target and not ramping

Behaviour:
- Reset (rst==0 at a clk edge):
  - duty_out=0, target reg=0, period counter=0, hold counter=0, state IDLE.
  - period_tick=0, tgt_ready=0, busy=0, at_target=1.
  - Reset mid-ramp aborts the ramp with the same values.
- Period counter:
  - Counts 0..PERIOD-1 and wraps.
  - period_tick is high while the counter==PERIOD-1.
  - Released from reset on the same edge as the PWM stage, so the tick aligns with the PWM wrap.
- Handshake:
  - tgt_ready = enable (registered-free, combinational from enable, low during reset).
  - Transfer occurs when tgt_valid&&tgt_ready at a clk edge; the target reg updates on that edge.
  - Retarget is allowed at any time, including mid-ramp. The ramp continues from the current duty_out; the hold counter is not reset on retarget.
- States:
  - IDLE: duty_out==target.
    - Accepted target != duty_out -> RAMP, hold counter cleared.
    - Accepted target == duty_out -> stays IDLE.
  - RAMP, on each period_tick:
    - hold counter++.
    - When it reaches HOLD_PERIODS: counter cleared and one step applied.
    - The first step therefore lands on the HOLD_PERIODS-th tick after entry.
- Step arithmetic, computed in DW+1 bits:
  - Up: duty_out = min(duty_out+STEP, target).
  - Down: duty_out = max(duty_out-STEP, target), with no underflow.
  - Wrap-around is never allowed.
  - When duty_out reaches target -> IDLE on the same edge.
- Glitch-free updates:
  - duty_out changes only on edges where period_tick==1, except enable-low and reset.
- Output flags:
  - busy = (state==RAMP).
  - at_target = (state==IDLE).
- Simultaneous events:
  - Target accepted on a tick cycle that would step: the step uses the old target, and the new target takes effect from the next edge.
  - This is the only ordering.
- enable low:
  - Next edge: duty_out=0, target=0, state IDLE, hold counter 0.
  - The period counter keeps running.
  - Re-enable starts from 0.

Optional Feature:
Macro DUTY_CLAMP_EN.
- Defined: accepted targets above MAX_DUTY are stored as MAX_DUTY, so duty_out never exceeds MAX_DUTY.
- Undefined: MAX_DUTY is ignored; full range 0..2^DW-1.

Decomposition:
- Package duty_pkg:
  - DW default.
  - PWM_PERIOD default.
  - State enum {IDLE, RAMP}.
  - Saturating step function.
- Sub-module period_timer: generic mod-PERIOD counter emitting period_tick. It is reusable by the PWM stage.

Test Plan:
All scenarios except 1 use PERIOD=8, STEP=16, HOLD_PERIODS=2.
1. Reset: hold rst=0 3 cycles with tgt_valid=1 -> duty_out=0, tgt_ready=0, busy=0, at_target=1, period_tick=0.
2. Ramp up: target 64 -> duty_out 16,32,48,64, one step every 16 clocks, each change on a period_tick edge; then busy=0, at_target=1.
3. Saturating step: from 64, target 70 -> single step to 70, no overshoot.
4. Retarget: from 64, target 0, then after step to 48 target 96 -> next steps 64,80,96.
5. enable low mid-ramp at duty 32 -> duty_out 0 next edge, tgt_ready 0, busy 0. Re-enable with target 32 -> 16,32.
6. Boundary: target 255 -> ends at 255 with no wrap. With DUTY_CLAMP_EN and MAX_DUTY=230 -> ends at 230. Also pulse rst=0 mid-ramp -> duty_out 0 next edge.
